// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and channel type for the I2S ADC receive path
package i2s_pkg;

  localparam int SAMPLE_W     = 24;
  localparam int SLOTS_PER_CH = 32;
  localparam int SLOT_W       = $clog2(SLOTS_PER_CH);

  // MSB arrives in slot 1 (one SCLK after the LRCK edge), LSB in slot 24
  localparam logic [SLOT_W-1:0] FIRST_BIT_SLOT = 5'd1;
  localparam logic [SLOT_W-1:0] LAST_BIT_SLOT  = 5'd24;

  // sdin is taken mid SCLK-high; the word is complete one clk later
  localparam logic [3:0] SAMPLE_PHASE = 4'hB;
  localparam logic [3:0] WRITE_PHASE  = SAMPLE_PHASE + 4'd1;

  // frame counter bits driven straight out as the ADC clocks
  localparam int MCLK_BIT = 1;
  localparam int SCLK_BIT = 3;
  localparam int LRCK_BIT = 9;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - frame counter, MCLK/SCLK/LRCK and capture strobes
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic  clk,
  input  logic  rst_n,
  output logic  mclk,
  output logic  sclk,
  output logic  lrck,
  output logic  bit_stb,
  output logic  lsb_stb,
  output logic  frame_start,
  output chan_e channel
);

  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] slot;
  logic [3:0]        phase;

  // free-running frame counter; one full wrap is one stereo frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + CNT_W'(1);
  end

  assign slot    = cnt[LRCK_BIT-1 -: SLOT_W];
  assign phase   = cnt[3:0];
  assign mclk    = cnt[MCLK_BIT];
  assign sclk    = cnt[SCLK_BIT];
  assign lrck    = cnt[LRCK_BIT];
  assign channel = chan_e'(cnt[LRCK_BIT]);

  assign bit_stb     = (phase == SAMPLE_PHASE) &&
                       (slot >= FIRST_BIT_SLOT) && (slot <= LAST_BIT_SLOT);
  // one clk after the slot-24 sample, when the whole word is in the shifter
  assign lsb_stb     = (phase == WRITE_PHASE) && (slot == LAST_BIT_SLOT);
  assign frame_start = (cnt == '0);

endmodule

// File: rtl/i2s_rx_fifo_wr.sv
// rtl/i2s_rx_fifo_wr.sv - I2S master receiver into the sample FIFO (I2S_RX_MONO_EN: left only)
module i2s_rx_fifo_wr
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int CNT_W    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                clr_ovf,
  output logic                mclk,
  output logic                sclk,
  output logic                lrck,
  input  logic                sdin,
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [SAMPLE_W-1:0] fifo_din,
  output logic                ch,
  output logic                overflow
);

  logic                bit_stb;
  logic                lsb_stb;
  logic                frame_start;
  chan_e               channel;
  logic                armed;
  logic [SAMPLE_W-1:0] shift;
  logic                wr_point;
  logic                pair_drop;
  logic                do_write;
  logic                do_drop;

  i2s_clkgen #(.CNT_W(CNT_W)) u_clkgen (
    .clk         (clk),
    .rst_n       (rst_n),
    .mclk        (mclk),
    .sclk        (sclk),
    .lrck        (lrck),
    .bit_stb     (bit_stb),
    .lsb_stb     (lsb_stb),
    .frame_start (frame_start),
    .channel     (channel)
  );

  // MSB-first deserializer; only the 24 data slots feed it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       shift <= '0;
    else if (bit_stb) shift <= {shift[SAMPLE_W-2:0], sdin};
  end

  // en is looked at only at frame start, so capture always begins on a left slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           armed <= 1'b0;
    else if (frame_start) armed <= en;
  end

`ifdef I2S_RX_MONO_EN
  assign wr_point  = lsb_stb && armed && (channel == LEFT);
  assign pair_drop = 1'b0;
`else
  logic left_drop;

  assign wr_point  = lsb_stb && armed;
  assign pair_drop = (channel == RIGHT) && left_drop;

  // a dropped left takes its right partner with it, keeping L/R order in the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              left_drop <= 1'b0;
    else if (wr_point && (channel == LEFT))  left_drop <= fifo_full;
  end
`endif

  assign do_write = wr_point && !pair_drop && !fifo_full;
  assign do_drop  = wr_point && !pair_drop &&  fifo_full;

  // FIFO write port: single-cycle strobe, data and channel hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr  <= 1'b0;
      fifo_din <= '0;
      ch       <= 1'b0;
    end else begin
      fifo_wr <= do_write;
      if (do_write) begin
        fifo_din <= shift;
        ch       <= channel;
      end
    end
  end

  // sticky overflow; a drop in the same cycle as clr_ovf wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (do_drop) overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule
